// File: rtl/bcd_display_scanner_if.sv
// Bus between a packed-BCD source and the display scanner: load strobe in,
// multiplexed digit drive and status pulses out.
interface bcd_display_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IW = $clog2(NUM_DIGITS);

  logic                    load;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic                    load_err;
  logic [3:0]              bcd_out;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [IW-1:0]           digit_idx;
  logic                    frame_tick;

  modport master (
    output load, bcd_in,
    input  load_err, bcd_out, an_n, digit_idx, frame_tick
  );

  modport slave (
    input  load, bcd_in,
    output load_err, bcd_out, an_n, digit_idx, frame_tick
  );
endinterface

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed BCD digit scanner with dead-time between digits, leading-zero
// blanking and frame-aligned display updates; blank digits present 4'hF.
module bcd_display_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 1000,
  parameter int DEADTIME   = 8,
  parameter bit LZB_EN     = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  bcd_display_scanner_if.slave        bus
);
  localparam int DW      = 4 * NUM_DIGITS;
  localparam int IW      = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (PRESCALE > DEADTIME) ? PRESCALE : DEADTIME;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] SHOW_LOAD  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LOAD = CW'((DEADTIME > 0) ? DEADTIME - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_SHOW,
    ST_BLANK
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_digit_idx;
  logic [DW-1:0]         r_shadow;
  logic [DW-1:0]         r_display;
  logic [NUM_DIGITS-1:0] r_an_n;
  logic [3:0]            r_bcd_out;
  logic                  r_frame_tick;
  logic                  r_load_err;

  logic                  w_all_bcd;
  logic                  w_load_ok;
  logic [IW-1:0]         w_next_idx;
  logic [DW-1:0]         w_show_disp;
  logic                  w_lit;
  logic                  w_enter_show;

  // NOTE: the flag gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    w_all_bcd = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (bus.bcd_in[4*k +: 4] > 4'd9) w_all_bcd = 1'b0;
    end
  end

  assign w_load_ok    = bus.load && w_all_bcd;
  assign w_next_idx   = (r_digit_idx == LAST_IDX) ? '0 : r_digit_idx + 1'b1;
  // At the frame boundary a coincident valid load bypasses the shadow register.
  assign w_show_disp  = (w_next_idx == '0) ? (w_load_ok ? bus.bcd_in : r_shadow) : r_display;
  assign w_lit        = !LZB_EN || (w_next_idx == '0) || ((w_show_disp >> (4 * w_next_idx)) != '0);
  assign w_enter_show = (r_cnt == '0) && ((r_state == ST_BLANK) || (DEADTIME == 0));

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_BLANK;
      r_cnt        <= '0;
      r_digit_idx  <= LAST_IDX;
      r_shadow     <= '0;
      r_display    <= '0;
      r_an_n       <= '1;
      r_bcd_out    <= 4'hF;
      r_frame_tick <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_load_err   <= bus.load && !w_all_bcd;
      r_frame_tick <= 1'b0;
      if (w_load_ok) r_shadow <= bus.bcd_in;

      if (w_enter_show) begin
        r_state      <= ST_SHOW;
        r_cnt        <= SHOW_LOAD;
        r_digit_idx  <= w_next_idx;
        r_frame_tick <= (w_next_idx == '0);
        if (w_next_idx == '0) r_display <= w_show_disp;
        if (w_lit) begin
          r_an_n    <= ~(NUM_DIGITS'(1) << w_next_idx);
          r_bcd_out <= w_show_disp[4*w_next_idx +: 4];
        end else begin
          r_an_n    <= '1;
          r_bcd_out <= 4'hF;
        end
      end else if (r_cnt == '0) begin
        // Only reachable from SHOW with a non-zero dead-time.
        r_state   <= ST_BLANK;
        r_cnt     <= BLANK_LOAD;
        r_an_n    <= '1;
        r_bcd_out <= 4'hF;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign bus.an_n       = r_an_n;
  assign bus.bcd_out    = r_bcd_out;
  assign bus.digit_idx  = r_digit_idx;
  assign bus.frame_tick = r_frame_tick;
  assign bus.load_err   = r_load_err;
endmodule
